// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch
// and load/store paths. Only one transaction is in flight at a time. Round-robin
// breaks ties, and a watchdog turns a hung memory access into an error completion.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  // status
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state, state_nx;
  logic        own_data, own_data_nx;    // owner of the in-flight transaction (1 = data port)
  logic        last_data, last_data_nx;  // most recent grant went to the data port
  logic [15:0] wd_cnt, wd_cnt_nx;
  logic [15:0] wd_inc;
  logic        done, abort;

  // next values of every registered output
  logic        if_gnt_nx, if_rvalid_nx, if_err_nx;
  logic        d_gnt_nx, d_rvalid_nx, d_err_nx;
  logic [31:0] if_rdata_nx, d_rdata_nx;
  logic        mem_req_nx, mem_we_nx, busy_nx;
  logic [31:0] mem_addr_nx, mem_wdata_nx;
  logic [3:0]  mem_be_nx;
  logic [31:0] cpl_rdata;

  // Next-state, arbitration, watchdog and completion routing
  always_comb begin
    state_nx     = state;
    own_data_nx  = own_data;
    last_data_nx = last_data;
    wd_cnt_nx    = wd_cnt;
    wd_inc       = wd_cnt + 16'd1;
    done         = 1'b0;
    abort        = 1'b0;
    cpl_rdata    = 32'd0;
    if_gnt_nx    = 1'b0;
    if_rvalid_nx = 1'b0;
    if_err_nx    = 1'b0;
    if_rdata_nx  = 32'd0;
    d_gnt_nx     = 1'b0;
    d_rvalid_nx  = 1'b0;
    d_err_nx     = 1'b0;
    d_rdata_nx   = 32'd0;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    mem_be_nx    = mem_be;

    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          // on a tie the port that did not win last time gets the grant
          own_data_nx  = d_req && !(if_req && last_data);
          last_data_nx = own_data_nx;
          wd_cnt_nx    = 16'd0;
          state_nx     = REQ;
          if (own_data_nx) begin
            mem_we_nx    = d_we;
            mem_addr_nx  = d_addr;
            mem_wdata_nx = d_wdata;
            mem_be_nx    = d_be;
            d_gnt_nx     = 1'b1;
          end else begin
            mem_we_nx    = 1'b0;
            mem_addr_nx  = if_addr;
            mem_wdata_nx = 32'd0;
            mem_be_nx    = 4'hF;
            if_gnt_nx    = 1'b1;
          end
        end
      end
      REQ: begin
        wd_cnt_nx = wd_inc;
        if (wd_inc == TIMEOUT_CNT) begin
          abort = 1'b1;
        end else if (mem_gnt) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        wd_cnt_nx = wd_inc;
        // a completion arriving on the expiry cycle still counts as good
        if (mem_rvalid) begin
          done = 1'b1;
        end else if (wd_inc == TIMEOUT_CNT) begin
          abort = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (done || abort) begin
      state_nx  = IDLE;
      cpl_rdata = (done && !mem_we) ? mem_rdata : 32'd0;
      if (own_data) begin
        d_rvalid_nx = 1'b1;
        d_err_nx    = abort;
        d_rdata_nx  = cpl_rdata;
      end else begin
        if_rvalid_nx = 1'b1;
        if_err_nx    = abort;
        if_rdata_nx  = cpl_rdata;
      end
    end

    mem_req_nx = (state_nx == REQ);
    busy_nx    = (state_nx != IDLE);
  end

  // FSM state, ownership and watchdog registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      own_data  <= 1'b0;
      last_data <= 1'b0;
      wd_cnt    <= 16'd0;
    end else begin
      state     <= state_nx;
      own_data  <= own_data_nx;
      last_data <= last_data_nx;
      wd_cnt    <= wd_cnt_nx;
    end
  end

  // Registered outputs, including the latched memory payload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
      if_err    <= 1'b0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= 32'd0;
      d_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= if_gnt_nx;
      if_rvalid <= if_rvalid_nx;
      if_rdata  <= if_rdata_nx;
      if_err    <= if_err_nx;
      d_gnt     <= d_gnt_nx;
      d_rvalid  <= d_rvalid_nx;
      d_rdata   <= d_rdata_nx;
      d_err     <= d_err_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      mem_be    <= mem_be_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios, a transaction-level
// reference model checked every cycle, and hand-computed literal expectations.
module tb_mem_port_arbiter;

  localparam int TMO = 8;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [3:0]  d_be = 4'd0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_gnt"}, if_gnt, 0);
    chk({tag, "_if_rvalid"}, if_rvalid, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_if_err"}, if_err, 0);
    chk({tag, "_d_gnt"}, d_gnt, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_d_err"}, d_err, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_act = 0;      // a transaction is outstanding
  bit          m_acc = 0;      // memory has accepted it
  bit          m_own_d = 0;
  bit          m_last_d = 0;
  int          m_age = 0;
  logic        e_if_gnt = 0, e_if_rvalid = 0, e_if_err = 0;
  logic        e_d_gnt = 0, e_d_rvalid = 0, e_d_err = 0;
  logic [31:0] e_if_rdata = 0, e_d_rdata = 0;
  logic        e_mem_req = 0, e_mem_we = 0, e_busy = 0;
  logic [31:0] e_mem_addr = 0, e_mem_wdata = 0;
  logic [3:0]  e_mem_be = 0;

  task automatic model_deliver(input logic err, input logic [31:0] rd);
    if (m_own_d) begin
      e_d_rvalid = 1; e_d_err = err; e_d_rdata = rd;
    end else begin
      e_if_rvalid = 1; e_if_err = err; e_if_rdata = rd;
    end
    m_act = 0;
  endtask

  // Model advances on each clock from the inputs seen at that edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act = 0; m_acc = 0; m_own_d = 0; m_last_d = 0; m_age = 0;
      e_if_gnt = 0; e_if_rvalid = 0; e_if_err = 0; e_if_rdata = 0;
      e_d_gnt = 0; e_d_rvalid = 0; e_d_err = 0; e_d_rdata = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0; e_mem_be = 0; e_busy = 0;
    end else begin
      e_if_gnt = 0; e_if_rvalid = 0; e_if_err = 0; e_if_rdata = 0;
      e_d_gnt = 0; e_d_rvalid = 0; e_d_err = 0; e_d_rdata = 0;
      if (!m_act) begin
        if (if_req || d_req) begin
          m_own_d = d_req && !(if_req && m_last_d);
          m_last_d = m_own_d;
          m_act = 1; m_acc = 0; m_age = 0;
          if (m_own_d) begin
            e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata; e_mem_be = d_be;
            e_d_gnt = 1;
          end else begin
            e_mem_we = 0; e_mem_addr = if_addr; e_mem_wdata = 0; e_mem_be = 4'hF;
            e_if_gnt = 1;
          end
        end
      end else begin
        m_age = m_age + 1;
        if (m_acc && mem_rvalid) model_deliver(1'b0, e_mem_we ? 32'd0 : mem_rdata);
        else if (m_age == TMO) model_deliver(1'b1, 32'd0);
        else if (!m_acc && mem_gnt) m_acc = 1;
      end
      e_mem_req = m_act && !m_acc;
      e_busy = m_act;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("cmp_if_gnt", if_gnt, e_if_gnt);
    chk("cmp_if_rvalid", if_rvalid, e_if_rvalid);
    chk("cmp_if_rdata", if_rdata, e_if_rdata);
    chk("cmp_if_err", if_err, e_if_err);
    chk("cmp_d_gnt", d_gnt, e_d_gnt);
    chk("cmp_d_rvalid", d_rvalid, e_d_rvalid);
    chk("cmp_d_rdata", d_rdata, e_d_rdata);
    chk("cmp_d_err", d_err, e_d_err);
    chk("cmp_mem_req", mem_req, e_mem_req);
    chk("cmp_mem_we", mem_we, e_mem_we);
    chk("cmp_mem_addr", mem_addr, e_mem_addr);
    chk("cmp_mem_wdata", mem_wdata, e_mem_wdata);
    chk("cmp_mem_be", mem_be, e_mem_be);
    chk("cmp_busy", busy, e_busy);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit gseq[8];
    bit rseq[8];
    int ng, nr, busy_cnt, req_cycles;
    logic had_gnt;

    // reset state
    repeat (2) tick();
    chk_zero("reset");

    // both requesters high from reset: D, F, D, F
    if_req = 1; if_addr = 32'h0000_0500;
    d_req = 1; d_we = 0; d_addr = 32'h0000_3000; d_wdata = 32'h0; d_be = 4'hF;
    reset_n = 1;
    ng = 0; nr = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      tick();
      if (d_gnt && ng < 8) begin gseq[ng] = 1; ng++; end
      if (if_gnt && ng < 8) begin gseq[ng] = 0; ng++; end
      if (d_rvalid && nr < 8) begin
        chk("alt_d_rdata", d_rdata, 32'h0000_3000 ^ K);
        rseq[nr] = 1; nr++;
      end
      if (if_rvalid && nr < 8) begin
        chk("alt_if_rdata", if_rdata, 32'h0000_0500 ^ K);
        rseq[nr] = 0; nr++;
      end
      had_gnt = mem_gnt;
      mem_gnt = mem_req;
      mem_rvalid = had_gnt;
      mem_rdata = had_gnt ? (mem_addr ^ K) : 32'd0;
    end
    if_req = 0; d_req = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    chk("alt_grant_count", ng, 4);
    chk("alt_rvalid_count", nr, 4);
    for (int i = 0; i < 4; i++) begin
      chk("alt_grant_order", gseq[i], (i % 2 == 0) ? 1 : 0);
      chk("alt_rvalid_order", rseq[i], (i % 2 == 0) ? 1 : 0);
    end
    repeat (2) tick();

    // single fetch
    if_addr = 32'h0000_0100; if_req = 1; busy_cnt = 0;
    tick();
    chk("fetch_if_gnt", if_gnt, 1);
    chk("fetch_d_gnt", d_gnt, 0);
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_mem_be", mem_be, 4'hF);
    chk("fetch_mem_we", mem_we, 0);
    chk("fetch_mem_addr", mem_addr, 32'h0000_0100);
    busy_cnt += busy;
    if_req = 0; mem_gnt = 1;
    tick();
    busy_cnt += busy;
    chk("fetch_if_gnt_pulse", if_gnt, 0);
    mem_gnt = 0;
    tick();
    busy_cnt += busy;
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    busy_cnt += busy;
    chk("fetch_if_rvalid", if_rvalid, 1);
    chk("fetch_if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("fetch_if_err", if_err, 0);
    chk("fetch_d_rvalid", d_rvalid, 0);
    mem_rvalid = 0; mem_rdata = 0;
    chk("fetch_busy_cycles", busy_cnt, 3);
    tick();

    // store
    d_req = 1; d_we = 1; d_addr = 32'h0000_2004; d_wdata = 32'h1234_5678; d_be = 4'b0011;
    tick();
    chk("store_d_gnt", d_gnt, 1);
    chk("store_mem_we", mem_we, 1);
    chk("store_mem_addr", mem_addr, 32'h0000_2004);
    chk("store_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("store_mem_be", mem_be, 4'b0011);
    d_req = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("store_d_rvalid", d_rvalid, 1);
    chk("store_d_rdata", d_rdata, 0);
    chk("store_d_err", d_err, 0);
    chk("store_if_rvalid", if_rvalid, 0);
    mem_rvalid = 0; mem_rdata = 0; d_we = 0;
    tick();

    // watchdog: memory never grants
    if_addr = 32'h0000_0040; if_req = 1;
    tick();
    if_req = 0; req_cycles = 0;
    for (int c = 0; c < 20 && !if_rvalid; c++) begin
      if (mem_req) req_cycles++;
      tick();
    end
    chk("tmo_req_cycles", req_cycles, 8);
    chk("tmo_if_rvalid", if_rvalid, 1);
    chk("tmo_if_err", if_err, 1);
    chk("tmo_if_rdata", if_rdata, 0);
    chk("tmo_mem_req_dropped", mem_req, 0);
    tick();
    // next request proceeds normally
    if_addr = 32'h0000_0200; if_req = 1;
    tick();
    chk("tmo_next_gnt", if_gnt, 1);
    if_req = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0BAD_F00D;
    tick();
    chk("tmo_next_rvalid", if_rvalid, 1);
    chk("tmo_next_err", if_err, 0);
    chk("tmo_next_rdata", if_rdata, 32'h0BAD_F00D);
    mem_rvalid = 0; mem_rdata = 0;
    tick();

    // completion on the expiry cycle is a good completion
    d_req = 1; d_we = 0; d_addr = 32'h0000_0080; d_be = 4'hF;
    tick();
    d_req = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0;
    repeat (6) tick();
    chk("exp_no_early_rvalid", d_rvalid, 0);
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    chk("exp_d_rvalid", d_rvalid, 1);
    chk("exp_d_err", d_err, 0);
    chk("exp_d_rdata", d_rdata, 32'hCAFE_F00D);
    mem_rvalid = 0; mem_rdata = 0;
    tick();

    // reset while waiting for memory
    if_addr = 32'h0000_0300; if_req = 1;
    tick();
    if_req = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0;
    chk("rst_in_wait_busy", busy, 1);
    reset_n = 0;
    #1;
    chk_zero("async_rst");
    tick();
    tick();
    reset_n = 1;
    mem_rvalid = 1; mem_rdata = 32'h0000_0077;
    tick();
    chk("rst_late_if_rvalid", if_rvalid, 0);
    chk("rst_late_d_rvalid", d_rvalid, 0);
    chk("rst_late_busy", busy, 0);
    mem_rvalid = 0; mem_rdata = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_after_if_rvalid", if_rvalid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
